// File: rtl/static_buff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : static_buff_pkg
// Brief    : Shared defaults for the multi-queue static buffer and the
//            round-robin pick helper used by its consumer-side scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package static_buff_pkg;

    localparam int unsigned c_NUMELEM = 4;
    localparam int unsigned c_BITDATA = 4;
    localparam int unsigned c_NUMFIFO = 8;
    localparam int unsigned c_RR_MAX  = 32;

    // First requesting index after 'last', wrapping modulo 'num'; returns
    // 'last' when nothing requests.
    function automatic int unsigned rr_pick(
        input logic [c_RR_MAX-1:0] req_vec,
        input int unsigned         last,
        input int unsigned         num
    );
        int unsigned w_idx;
        int unsigned w_pick;
        logic        w_found;
        w_pick  = last;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= c_RR_MAX; i++) begin
            w_idx = (last + i) % num;
            if (!w_found && (i <= num) && req_vec[w_idx[4:0]]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
        return w_pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_outq.sv
`default_nettype none
// ============================================================================
// Module   : sched_outq
// Brief    : First-word-fall-through synchronous FIFO with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
module sched_outq #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 7,
    parameter int unsigned OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             vld,
    output logic [OCCW-1:0]  occ
);

    localparam int unsigned c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wptr;
    logic [c_PTRW-1:0] r_rptr;
    logic [OCCW-1:0]   r_occ;
    logic              w_rd;

    assign w_rd    = rd_en && (r_occ != '0);
    assign vld     = (r_occ != '0);
    assign occ     = r_occ;
    assign rd_data = vld ? r_mem[r_rptr] : '0;

    // Write while full is legal only together with a read; the write slot
    // then equals the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= (r_wptr == c_PTRW'(DEPTH - 1)) ? '0 : r_wptr + c_PTRW'(1);
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == c_PTRW'(DEPTH - 1)) ? '0 : r_rptr + c_PTRW'(1);
            end
            if (wr_en && !w_rd) begin
                r_occ <= r_occ + OCCW'(1);
            end else if (w_rd && !wr_en) begin
                r_occ <= r_occ - OCCW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/static_buff_pop_sched.sv
`default_nettype none
// ============================================================================
// Module   : static_buff_pop_sched
// Brief    : Round-robin pop scheduler for the static buffer with a
//            credit-protected FWFT output queue.
// Revision : 1.0 - initial release
// ============================================================================
module static_buff_pop_sched
    import static_buff_pkg::*;
#(
    parameter int unsigned NUMELEM  = c_NUMELEM,
    parameter int unsigned BITDATA  = c_BITDATA,
    parameter int unsigned NUMFIFO  = c_NUMFIFO,
    parameter int unsigned RDLAT    = 1,
    parameter int unsigned OUTDEPTH = 2,
    parameter int unsigned BITELEM  = $clog2(NUMELEM),
    parameter int unsigned BITFIFO  = $clog2(NUMFIFO)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buf_ready,
    input  logic               push_seen,
    input  logic [BITFIFO-1:0] pu_prt_seen,
    output logic               pop,
    output logic [BITFIFO-1:0] po_prt,
    input  logic [BITDATA-1:0] po_dout,
    output logic               out_vld,
    output logic [BITFIFO-1:0] out_prt,
    output logic [BITDATA-1:0] out_data,
    input  logic               out_rdy,
    output logic [NUMFIFO-1:0] nonempty
);

    localparam int unsigned c_OCCW = $clog2(OUTDEPTH + 1);
    localparam int unsigned c_QW   = BITFIFO + BITDATA;

    logic [BITFIFO-1:0] r_last;
    logic [BITFIFO-1:0] w_pick;
    logic [RDLAT-1:0]   r_pipe_vld;
    logic [BITFIFO-1:0] r_pipe_prt [RDLAT];
    logic [c_OCCW-1:0]  w_occ;
    logic [c_QW-1:0]    w_rd_data;
    logic               w_deq;
    logic               w_credit_ok;
    int unsigned        w_inflight;

    for (genvar q = 0; q < NUMFIFO; q++) begin : g_cnt
        logic [BITELEM:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc       = push_seen && (pu_prt_seen == BITFIFO'(q));
        assign w_dec       = pop && (po_prt == BITFIFO'(q));
        assign nonempty[q] = (r_cnt != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + (BITELEM + 1)'(1);
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - (BITELEM + 1)'(1);
            end
        end
    end

    assign w_pick = BITFIFO'(rr_pick(32'(nonempty), 32'(r_last), NUMFIFO));

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < RDLAT; i++) begin
            w_inflight = w_inflight + 32'(r_pipe_vld[i]);
        end
    end

    // Entries already owed to the output queue must fit, counting the slot
    // that a dequeue in this very cycle frees up.
    assign w_deq       = out_vld && out_rdy;
    assign w_credit_ok = (32'(w_occ) + w_inflight) < (OUTDEPTH + 32'(w_deq));
    assign pop         = !rst && buf_ready && (|nonempty) && w_credit_ok;
    assign po_prt      = pop ? w_pick : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= BITFIFO'(NUMFIFO - 1);
        end else if (pop) begin
            r_last <= w_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RDLAT; i++) begin
                r_pipe_prt[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= pop;
            r_pipe_prt[0] <= po_prt;
            for (int i = 1; i < RDLAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_prt[i] <= r_pipe_prt[i-1];
            end
        end
    end

    sched_outq #(
        .DEPTH (OUTDEPTH),
        .WIDTH (c_QW),
        .OCCW  (c_OCCW)
    ) u_outq (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_pipe_vld[RDLAT-1]),
        .wr_data ({r_pipe_prt[RDLAT-1], po_dout}),
        .rd_en   (out_rdy),
        .rd_data (w_rd_data),
        .vld     (out_vld),
        .occ     (w_occ)
    );

    assign out_prt  = w_rd_data[c_QW-1:BITDATA];
    assign out_data = w_rd_data[BITDATA-1:0];

endmodule
`default_nettype wire

// File: doc/static_buff_pop_sched.md
# static_buff_pop_sched

Consumer-side scheduler for the multi-queue static buffer. It shadows per-queue occupancy from the buffer's push stream and selects a non-empty queue round-robin. It issues the buffer's pop port, `pop`/`po_prt`, and captures `po_dout` after the fixed read latency. The result goes to a downstream valid/ready port through a credit-protected output queue, so popped data is never dropped.

## Interface
Parameters:
- NUMELEM, 4: entries per queue in the buffer.
- BITDATA, 4: data width.
- NUMFIFO, 8: number of queues.
- RDLAT, 1: cycles from `pop` to valid `po_dout` (>=1).
- OUTDEPTH, 2: output queue depth. Must be >= RDLAT+1.
- Derived:
  - BITELEM = $clog2(NUMELEM)
  - BITFIFO = $clog2(NUMFIFO)

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high. Clock is clk.
- buf_ready  in  1  buffer init done. No pop is issued while low.
- push_seen  in  1  a push is accepted by the buffer this cycle.
- pu_prt_seen  in  BITFIFO  queue index of that push.
- pop  out  1  pop request to the buffer.
- po_prt  out  BITFIFO  queue to pop. Don't-care when `pop`=0; driven 0.
- po_dout  in  BITDATA  buffer read data, RDLAT cycles after `pop`.
- out_vld  out  1  output entry available.
- out_prt  out  BITFIFO  source queue of the output entry.
- out_data  out  BITDATA  output data.
- out_rdy  in  1  downstream accepts the entry.
- nonempty  out  NUMFIFO  per-queue "shadow count > 0" bits.

## Operation
- **Shadow counts.** cnt[q] is BITELEM+1 bits, one per queue, reset 0.
  - +1 on `push_seen` to q.
  - -1 on `pop` to q.
  - Push and pop to the same q in one cycle: unchanged.
  - Pushing to a full queue is an upstream protocol violation. The bench flags it; the RTL does not correct it.
- **Round-robin pointer.** `last` is BITFIFO bits, reset NUMFIFO-1.
  - Candidate = first q with cnt[q]>0, searching (last+1) .. (last+NUMFIFO) mod NUMFIFO.
  - `last` updates to the granted q only when `pop` fires.
- **Issue condition.** Pop fires when all of the following hold:
  - `pop = buf_ready && |nonempty && (occ + inflight - (out_vld && out_rdy)) < OUTDEPTH`.
  - `occ` is the output queue occupancy.
  - `inflight` is the number of valid stages in the latency pipe.
  - This gives a combinational path from `out_rdy` to `pop`, which is accepted.
- **Latency pipe.** RDLAT stages of {valid, prt}, cleared on rst.
  - At the last stage, {prt, po_dout} is written into the output queue.
- **Output queue.** Depth OUTDEPTH, first-word-fall-through.
  - `out_vld` = occ>0.
  - Dequeue on `out_vld && out_rdy`.
  - Write and dequeue in the same cycle are both honoured, including when full (the credit rule guarantees space).
- **Credit invariant.** occ + inflight <= OUTDEPTH at all times. Overflow is impossible by construction.
- **`buf_ready` low mid-operation.** No new pops. In-flight reads still complete and count updates continue.

## Timing
- Reset values:
  - `pop`=0, `po_prt`=0.
  - `out_vld`=0, `out_prt`=0, `out_data`=0.
  - `nonempty`=0.
  - All counts, pipe and queue cleared; `last`=NUMFIFO-1.
- A push seen in cycle t makes that queue eligible in cycle t+1.
- Pop in cycle t: `po_dout` is sampled at the end of cycle t+RDLAT. `out_vld` rises in t+RDLAT+1 if the queue was empty.
- Minimum push-to-out latency is RDLAT+2 cycles.
- Sustained throughput is one entry per cycle with `out_rdy`=1 and OUTDEPTH >= RDLAT+1.
- With `out_rdy`=0, at most OUTDEPTH pops are outstanding; then `pop` stays low.
- Wrap: the pointer rolls from NUMFIFO-1 to 0. Counts never wrap under legal stimulus.
- rst asserted mid-operation clears everything on the next edge. In-flight data is discarded and `po_dout` is ignored while in reset.

## Structure
- Package `static_buff_pkg`:
  - default NUMELEM/BITDATA/NUMFIFO, shared with the buffer.
  - round-robin pick function `rr_pick(req_vec, last)`.
- One sub-module, `sched_outq`: parameterised FWFT sync FIFO (OUTDEPTH x (BITFIFO+BITDATA)) with an occupancy output.
- Counts, pointer, credit logic and latency pipe stay in the top module.

## Test plan
- **Reset.** Assert rst for 2 cycles with pushes active -> all outputs 0 and `nonempty`=0 for the first cycle after release.
- **Round-robin fairness.** Push 2 entries each to queues 1, 4, 6 with `out_rdy`=1 -> pop order is 1,4,6,1,4,6. `out_data` matches the pushed data per queue in FIFO order.
- **Backpressure.** RDLAT=1, OUTDEPTH=2, `out_rdy`=0, queue 3 holds 4 entries -> exactly 2 pops issued, `out_vld`=1, queue 3 count=2. Raising `out_rdy` -> remaining 2 drained, back-to-back 1/cycle.
- **Simultaneous push and pop.** Queue 0 has count 1; push to 0 in the same cycle pop fires on 0 -> count stays 1, `nonempty[0]`=1, next cycle pops 0 again.
- **`buf_ready` gating.** Drop `buf_ready` for 3 cycles with queues non-empty -> `pop`=0 in those cycles, an in-flight entry still appears on out, scheduling resumes with the pointer unchanged.
- **Reset mid-flight.** rst during an outstanding pop -> no `out_vld` afterwards, counts 0, a new push/pop sequence is correct.
